// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-type names and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam string PARITY_NONE  = "none";
    localparam string PARITY_EVEN  = "even";
    localparam string PARITY_ODD   = "odd";
    localparam string PARITY_MARK  = "mark";
    localparam string PARITY_SPACE = "space";

    function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_parity.sv
// Expected parity bit for a data word; shared by the TX and RX paths.
module uart_parity import uart_pkg::*; #(
    parameter int    DataWidth  = 8,
    parameter string ParityType = "none"
) (
    input  logic [DataWidth-1:0] data_i,
    output logic                 parity_o
);

    // Constant parity types still fold in data_i so the port never dangles.
    if (ParityType == PARITY_EVEN) begin : g_even
        assign parity_o = ^data_i;
    end else if (ParityType == PARITY_ODD) begin : g_odd
        assign parity_o = ~^data_i;
    end else if (ParityType == PARITY_MARK) begin : g_mark
        assign parity_o = 1'b1 | (^data_i);
    end else if (ParityType == PARITY_SPACE || ParityType == PARITY_NONE) begin : g_space
        assign parity_o = 1'b0 & (^data_i);
    end else begin : g_bad
        $error("uart_parity: unsupported ParityType '%s'", ParityType);
        assign parity_o = 1'b0 & (^data_i);
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, parity and stop-bit checking.
module uart_rx import uart_pkg::*; #(
    parameter int    ClockFrequency = 100000000,
    parameter int    BaudRate       = 115200,
    parameter int    DataWidth      = 8,
    parameter string ParityType     = "none",
    parameter int    StopBits       = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rx_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CPB = clocks_per_bit(ClockFrequency, BaudRate);
    localparam int H   = CPB / 2;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DataWidth + 1);
    localparam bit HAS_PARITY = (ParityType != PARITY_NONE);

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DataWidth - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(StopBits - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx: ClockFrequency/BaudRate must be >= 4 (got %0d)", CPB);
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
        $error("uart_rx: StopBits must be 1 or 2 (got %0d)", StopBits);
    end

    logic                 rx_meta_q, rx_s_q, rx_q;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DataWidth-1:0] shift_q;
    logic                 par_q;
    logic                 stop_err_q;
    logic [DataWidth-1:0] data_q;
    logic                 valid_q, parity_err_q, frame_err_q;

    logic tick;
    logic stop_err_d;
    logic exp_parity;

    uart_parity #(
        .DataWidth (DataWidth),
        .ParityType(ParityType)
    ) u_parity (
        .data_i  (shift_q),
        .parity_o(exp_parity)
    );

    // The start bit is sampled half a bit in; every later sample is a full bit on.
    assign tick       = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);
    assign stop_err_d = stop_err_q | ~rx_s_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_q         <= 1'b1;
            state_q      <= WAIT_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop_err_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_q      <= rx_s_q;
            valid_q   <= 1'b0;

            if (state_q == WAIT_IDLE || state_q == IDLE || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            case (state_q)
                WAIT_IDLE: begin
                    if (rx_s_q) state_q <= IDLE;
                end
                IDLE: begin
                    if (rx_q && !rx_s_q) state_q <= START;
                end
                START: begin
                    if (tick) begin
                        bit_cnt_q  <= '0;
                        stop_err_q <= 1'b0;
                        state_q    <= rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rx_s_q, shift_q[DataWidth-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= HAS_PARITY ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        par_q   <= rx_s_q;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            data_q       <= shift_q;
                            frame_err_q  <= stop_err_d;
                            parity_err_q <= HAS_PARITY && (par_q != exp_parity);
                            valid_q      <= 1'b1;
                            bit_cnt_q    <= '0;
                            state_q      <= stop_err_d ? WAIT_IDLE : IDLE;
                        end else begin
                            stop_err_q <= stop_err_d;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=16: one receiver per parity type sharing a single rx line.
module tb_uart_rx;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int CPB    = 16;
    localparam int H      = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    // index 0: none, 1: even, 2: odd, 3: mark, 4: space
    logic [7:0] data_w  [5];
    logic       valid_w [5];
    logic       pe_w    [5];
    logic       fe_w    [5];
    logic       busy_w  [5];

    uart_rx #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataWidth(8), .ParityType("none"), .StopBits(1)) u_none (
        .clk_i(clk), .reset_i(reset), .rx_i(rx), .data_o(data_w[0]), .valid_o(valid_w[0]),
        .parity_err_o(pe_w[0]), .frame_err_o(fe_w[0]), .busy_o(busy_w[0]));
    uart_rx #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataWidth(8), .ParityType("even"), .StopBits(1)) u_even (
        .clk_i(clk), .reset_i(reset), .rx_i(rx), .data_o(data_w[1]), .valid_o(valid_w[1]),
        .parity_err_o(pe_w[1]), .frame_err_o(fe_w[1]), .busy_o(busy_w[1]));
    uart_rx #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataWidth(8), .ParityType("odd"), .StopBits(1)) u_odd (
        .clk_i(clk), .reset_i(reset), .rx_i(rx), .data_o(data_w[2]), .valid_o(valid_w[2]),
        .parity_err_o(pe_w[2]), .frame_err_o(fe_w[2]), .busy_o(busy_w[2]));
    uart_rx #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataWidth(8), .ParityType("mark"), .StopBits(1)) u_mark (
        .clk_i(clk), .reset_i(reset), .rx_i(rx), .data_o(data_w[3]), .valid_o(valid_w[3]),
        .parity_err_o(pe_w[3]), .frame_err_o(fe_w[3]), .busy_o(busy_w[3]));
    uart_rx #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataWidth(8), .ParityType("space"), .StopBits(1)) u_space (
        .clk_i(clk), .reset_i(reset), .rx_i(rx), .data_o(data_w[4]), .valid_o(valid_w[4]),
        .parity_err_o(pe_w[4]), .frame_err_o(fe_w[4]), .busy_o(busy_w[4]));

    int         vcnt  [5] = '{default: 0};
    int         vtime [5] = '{default: 0};
    logic [7:0] vdata [5];
    logic       vpe   [5];
    logic       vfe   [5];
    int         pulse_t [$];
    logic [7:0] pulse_d [$];
    logic       pulse_e [$];

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (valid_w[i] === 1'b1) begin
                vcnt[i]++;
                vtime[i] = pcyc;
                vdata[i] = data_w[i];
                vpe[i]   = pe_w[i];
                vfe[i]   = fe_w[i];
                if (i == 0) begin
                    pulse_t.push_back(pcyc);
                    pulse_d.push_back(data_w[0]);
                    pulse_e.push_back(pe_w[0] | fe_w[0]);
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int t0c   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives up to nb bits of a frame, starting at a falling clock edge; par < 0 means no parity bit.
    task automatic send_frame(input logic [7:0] d, input int par, input logic stop_v, input int nb);
        logic [10:0] bits;
        int n;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (par >= 0) begin
            bits[9]  = par[0];
            bits[10] = stop_v;
            n = 11;
        end else begin
            bits[9] = stop_v;
            n = 10;
        end
        if (nb < n) n = nb;
        t0c = pcyc;
        for (int b = 0; b < n; b++) begin
            rx = bits[b];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    string pname [4] = '{"even", "odd", "mark", "space"};
    logic  pgood [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int base;

        reset = 1'b1;
        rx    = 1'b1;
        settle(3);
        check("rst_busy", busy_w[0], 1);
        check("rst_valid", valid_w[0], 0);
        check("rst_data", data_w[0], 0);
        check("rst_pe", pe_w[0], 0);
        check("rst_fe", fe_w[0], 0);
        @(negedge clk);
        reset = 1'b0;
        settle(3);
        check("idle_busy", busy_w[0], 0);

        // 8N1 0xA5 with latency check
        @(negedge clk);
        base = vcnt[0];
        send_frame(8'hA5, -1, 1'b1, 99);
        settle(CPB);
        check("a5_count", vcnt[0], base + 1);
        check("a5_latency", vtime[0] - t0c, 2 + H + 9 * CPB + 1);
        check("a5_data", vdata[0], 8'hA5);
        check("a5_pe", vpe[0], 0);
        check("a5_fe", vfe[0], 0);
        check("a5_busy", busy_w[0], 0);

        // 0x03 with wrong and then right parity bit, each parity type
        for (int k = 0; k < 4; k++) begin
            automatic int idx = k + 1;
            base = vcnt[idx];
            @(negedge clk);
            send_frame(8'h03, int'(!pgood[k]), 1'b1, 99);
            settle(CPB);
            check($sformatf("%s_bad_count", pname[k]), vcnt[idx], base + 1);
            check($sformatf("%s_bad_data", pname[k]), vdata[idx], 8'h03);
            check($sformatf("%s_bad_pe", pname[k]), vpe[idx], 1);
            check($sformatf("%s_bad_fe", pname[k]), vfe[idx], 0);
            @(negedge clk);
            send_frame(8'h03, int'(pgood[k]), 1'b1, 99);
            settle(CPB);
            check($sformatf("%s_good_count", pname[k]), vcnt[idx], base + 2);
            check($sformatf("%s_good_pe", pname[k]), vpe[idx], 0);
        end

        // framing error followed by a held-low break
        @(negedge clk);
        base = vcnt[0];
        send_frame(8'h5A, -1, 1'b0, 99);
        rx = 1'b0;
        settle(3 * CPB);
        check("brk_count", vcnt[0], base + 1);
        check("brk_data", vdata[0], 8'h5A);
        check("brk_fe", vfe[0], 1);
        check("brk_pe", vpe[0], 0);
        check("brk_busy", busy_w[0], 1);
        @(negedge clk);
        rx = 1'b1;
        settle(3 * CPB);
        check("brk_no_extra", vcnt[0], base + 1);
        check("brk_idle", busy_w[0], 0);
        @(negedge clk);
        send_frame(8'h3C, -1, 1'b1, 99);
        settle(CPB);
        check("post_brk_count", vcnt[0], base + 2);
        check("post_brk_data", vdata[0], 8'h3C);
        check("post_brk_fe", vfe[0], 0);

        // 4-cycle glitch on the line
        @(negedge clk);
        base = vcnt[0];
        rx  = 1'b0;
        t0c = pcyc;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_hi", busy_w[0], 1);
        while (pcyc < t0c + 2 + H + 2) @(negedge clk);
        check("glitch_busy_lo", busy_w[0], 0);
        settle(2 * CPB);
        check("glitch_no_valid", vcnt[0], base);

        // reset in the middle of a 0xFF frame
        @(negedge clk);
        base = vcnt[0];
        send_frame(8'hFF, -1, 1'b1, 5);
        reset = 1'b1;
        settle(1);
        check("midrst_busy", busy_w[0], 1);
        check("midrst_valid", valid_w[0], 0);
        check("midrst_data", data_w[0], 0);
        check("midrst_pe", pe_w[0], 0);
        check("midrst_fe", fe_w[0], 0);
        @(negedge clk);
        reset = 1'b0;
        settle(12 * CPB);
        check("midrst_no_valid", vcnt[0], base);
        @(negedge clk);
        send_frame(8'h81, -1, 1'b1, 99);
        settle(CPB);
        check("after_rst_count", vcnt[0], base + 1);
        check("after_rst_data", vdata[0], 8'h81);
        check("after_rst_err", vpe[0] | vfe[0], 0);

        // three back-to-back frames
        pulse_t.delete();
        pulse_d.delete();
        pulse_e.delete();
        @(negedge clk);
        send_frame(8'h00, -1, 1'b1, 99);
        send_frame(8'hFF, -1, 1'b1, 99);
        send_frame(8'h55, -1, 1'b1, 99);
        settle(CPB);
        check("b2b_pulses", pulse_t.size(), 3);
        if (pulse_t.size() == 3) begin
            check("b2b_gap1", pulse_t[1] - pulse_t[0], 10 * CPB);
            check("b2b_gap2", pulse_t[2] - pulse_t[1], 10 * CPB);
            check("b2b_d0", pulse_d[0], 8'h00);
            check("b2b_d1", pulse_d[1], 8'hFF);
            check("b2b_d2", pulse_d[2], 8'h55);
            check("b2b_err", {pulse_e[0], pulse_e[1], pulse_e[2]}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
